// File: rtl/operand_stage.sv
// Operand stage: decodes the operand class from the opcode and registers per-channel operands behind a valid/ready skid-free stage.
// Optional write-back forwarding is enabled by defining OPSTAGE_FWD_EN.
module operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_OPS = 2,
  parameter int STALL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                opcode,
  input  logic [NUM_OPS*XLEN-1:0]   dec_data,
  input  logic [NUM_OPS*XLEN-1:0]   rf_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic [NUM_OPS*XLEN-1:0]   op_data,
  output logic [1:0]                op_class,
  output logic [6:0]                op_opcode,
  output logic [STALL_W-1:0]        stall_cnt
`ifdef OPSTAGE_FWD_EN
  ,
  input  logic                      wb_en,
  input  logic [4:0]                wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  input  logic [NUM_OPS*5-1:0]      rs_addr
`endif
);

  localparam logic [1:0]         CLS_NONE  = 2'b00;
  localparam logic [1:0]         CLS_IMM   = 2'b01;
  localparam logic [1:0]         CLS_REG   = 2'b10;
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  logic                    out_valid_r;
  logic [NUM_OPS*XLEN-1:0] op_data_r;
  logic [1:0]              op_class_r;
  logic [6:0]              op_opcode_r;
  logic [STALL_W-1:0]      stall_cnt_r;

  logic [1:0]              class_s;
  logic [NUM_OPS*XLEN-1:0] data_nxt_s;
  logic                    in_ready_s;
  logic                    capture_s;
  logic                    stall_s;

  assign in_ready_s = !out_valid_r || out_ready;
  assign capture_s  = in_valid && in_ready_s && !flush;
  assign stall_s    = out_valid_r && !out_ready;

  // Opcode class decode; IMM is checked first so it wins over REG.
  always_comb begin
    class_s = CLS_NONE;
    if ((opcode[6:3] == 4'b0000) || (opcode[6:4] == 3'b001) || (opcode[6:2] == 5'b11001)) begin
      class_s = CLS_IMM;
    end else if ((opcode[6:4] == 3'b011) || (opcode[6:2] == 5'b01011) || (opcode[6:2] == 5'b10100)) begin
      class_s = CLS_REG;
    end else begin
      class_s = CLS_NONE;
    end
  end

  // Per-channel operand selection for the next capture; NONE keeps the held value.
  always_comb begin
    data_nxt_s = op_data_r;
    for (int k = 0; k < NUM_OPS; k++) begin
      case (class_s)
        CLS_IMM: data_nxt_s[k*XLEN +: XLEN] = dec_data[k*XLEN +: XLEN];
        CLS_REG: begin
`ifdef OPSTAGE_FWD_EN
          if (wb_en && (wb_addr == rs_addr[k*5 +: 5]) && (wb_addr != 5'd0)) begin
            data_nxt_s[k*XLEN +: XLEN] = wb_data;
          end else begin
            data_nxt_s[k*XLEN +: XLEN] = rf_data[k*XLEN +: XLEN];
          end
`else
          data_nxt_s[k*XLEN +: XLEN] = rf_data[k*XLEN +: XLEN];
`endif
        end
        default: data_nxt_s[k*XLEN +: XLEN] = op_data_r[k*XLEN +: XLEN];
      endcase
    end
  end

  // Stage entry register and handshake state; reset beats flush and capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      op_data_r   <= {(NUM_OPS*XLEN){1'b0}};
      op_class_r  <= CLS_NONE;
      op_opcode_r <= 7'd0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      op_data_r   <= data_nxt_s;
      op_class_r  <= class_s;
      op_opcode_r <= opcode;
    end else if (flush || (out_valid_r && out_ready)) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating back-pressure counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + STALL_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign op_data   = op_data_r;
  assign op_class  = op_class_r;
  assign op_opcode = op_opcode_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage (XLEN=32, NUM_OPS=2), plus a STALL_W=2 instance for saturation.
module tb_operand_stage;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [63:0] dec_data;
  logic [63:0] rf_data;
  logic        in_valid;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [63:0] op_data,   op_data2;
  logic [1:0]  op_class,  op_class2;
  logic [6:0]  op_opcode, op_opcode2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

`ifdef OPSTAGE_FWD_EN
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [9:0]  rs_addr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  operand_stage #(.XLEN(32), .NUM_OPS(2), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .dec_data(dec_data), .rf_data(rf_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .op_data(op_data), .op_class(op_class), .op_opcode(op_opcode),
    .stall_cnt(stall_cnt)
`ifdef OPSTAGE_FWD_EN
    , .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rs_addr(rs_addr)
`endif
  );

  operand_stage #(.XLEN(32), .NUM_OPS(2), .STALL_W(2)) dut_sat (
    .clk(clk), .rst(rst), .opcode(opcode), .dec_data(dec_data), .rf_data(rf_data),
    .in_valid(in_valid), .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .flush(flush), .op_data(op_data2), .op_class(op_class2), .op_opcode(op_opcode2),
    .stall_cnt(stall_cnt2)
`ifdef OPSTAGE_FWD_EN
    , .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rs_addr(rs_addr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; opcode = 7'b0010011;
    dec_data = 64'h1234_5678_9ABC_DEF0; rf_data = 64'd0; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (op_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", op_data); end
    n_cmp++; if (op_class !== 2'b00) begin n_fail++; $display("FAIL reset_class got %b want 00", op_class); end
    n_cmp++; if (op_opcode !== 7'd0) begin n_fail++; $display("FAIL reset_opcode got %h want 0", op_opcode); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    tick();
  endtask

  task automatic test_imm();
    in_valid = 1'b1; opcode = 7'b0010011;
    dec_data = {32'h5, 32'hA}; rf_data = {32'h1, 32'h2};
    tick();
    in_valid = 1'b0;
    n_cmp++; if (op_data !== {32'h5, 32'hA}) begin n_fail++; $display("FAIL imm_data got %h want %h", op_data, {32'h5, 32'hA}); end
    n_cmp++; if (op_class !== 2'b01) begin n_fail++; $display("FAIL imm_class got %b want 01", op_class); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL imm_valid got %b want 1", out_valid); end
    n_cmp++; if (op_opcode !== 7'b0010011) begin n_fail++; $display("FAIL imm_opcode got %b want 0010011", op_opcode); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL imm_drain got %b want 0", out_valid); end
    n_cmp++; if (op_data !== {32'h5, 32'hA}) begin n_fail++; $display("FAIL imm_hold got %h want %h", op_data, {32'h5, 32'hA}); end
  endtask

  task automatic test_reg_none();
    in_valid = 1'b1; opcode = 7'b0110011;
    dec_data = {32'h77, 32'h88}; rf_data = {32'h11, 32'h22};
    tick();
    n_cmp++; if (op_data !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL reg_data got %h want %h", op_data, {32'h11, 32'h22}); end
    n_cmp++; if (op_class !== 2'b10) begin n_fail++; $display("FAIL reg_class got %b want 10", op_class); end
    opcode = 7'b1100011; dec_data = {32'h99, 32'hAA}; rf_data = {32'h33, 32'h44};
    tick();
    in_valid = 1'b0;
    n_cmp++; if (op_data !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL none_data got %h want %h", op_data, {32'h11, 32'h22}); end
    n_cmp++; if (op_class !== 2'b00) begin n_fail++; $display("FAIL none_class got %b want 00", op_class); end
    n_cmp++; if (op_opcode !== 7'b1100011) begin n_fail++; $display("FAIL none_opcode got %b want 1100011", op_opcode); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL none_valid got %b want 1", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
    in_valid = 1'b1; out_ready = 1'b1; opcode = 7'b0000011; rf_data = 64'd0;
    for (int i = 0; i < 3; i++) begin
      exp_d = {32'h100 + 32'(i), 32'h200 + 32'(i)};
      dec_data = exp_d;
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (op_data !== exp_d) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, op_data, exp_d); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    rst = 1'b0; tick(); rst = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0; opcode = 7'b0010011;
    dec_data = {32'hCAFE, 32'hBEEF}; rf_data = 64'd0;
    tick();
    dec_data = {32'h1111, 32'h2222};
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_cmp++; if (op_data !== {32'hCAFE, 32'hBEEF}) begin n_fail++; $display("FAIL bp_data got %h want %h", op_data, {32'hCAFE, 32'hBEEF}); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_stall5 got %0d want 5", stall_cnt); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
    tick();
    n_cmp++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL bp_stall6 got %0d want 6", stall_cnt); end
    n_cmp++; if (stall_cnt2 !== 2'd3) begin n_fail++; $display("FAIL bp_sat got %0d want 3", stall_cnt2); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL bp_stall_hold got %0d want 6", stall_cnt); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0; opcode = 7'b0010011;
    dec_data = {32'hF00D, 32'hFACE};
    tick();
    flush = 1'b1; dec_data = {32'h5555, 32'h6666};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_cmp++; if (op_data !== {32'hF00D, 32'hFACE}) begin n_fail++; $display("FAIL flush_data got %h want %h", op_data, {32'hF00D, 32'hFACE}); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; opcode = 7'b0110011;
    rf_data = {32'hABCD, 32'h1234};
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    n_cmp++; if (op_data !== 64'd0) begin n_fail++; $display("FAIL rmid_data got %h want 0", op_data); end
    n_cmp++; if (op_class !== 2'b00) begin n_fail++; $display("FAIL rmid_class got %b want 00", op_class); end
    n_cmp++; if (op_opcode !== 7'd0) begin n_fail++; $display("FAIL rmid_opcode got %h want 0", op_opcode); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_stall got %0d want 0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

`ifdef OPSTAGE_FWD_EN
  task automatic test_forwarding();
    in_valid = 1'b1; out_ready = 1'b1; opcode = 7'b0110011;
    rf_data = {32'h11, 32'h22}; rs_addr = {5'd7, 5'd5};
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    tick();
    n_cmp++; if (op_data !== {32'h11, 32'hDEAD}) begin n_fail++; $display("FAIL fwd_hit got %h want %h", op_data, {32'h11, 32'hDEAD}); end
    rs_addr = {5'd7, 5'd0}; wb_addr = 5'd0;
    tick();
    n_cmp++; if (op_data !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL fwd_x0 got %h want %h", op_data, {32'h11, 32'h22}); end
    opcode = 7'b0010011; dec_data = {32'h3, 32'h4}; rs_addr = {5'd7, 5'd5}; wb_addr = 5'd5;
    tick();
    n_cmp++; if (op_data !== {32'h3, 32'h4}) begin n_fail++; $display("FAIL fwd_imm got %h want %h", op_data, {32'h3, 32'h4}); end
    in_valid = 1'b0; wb_en = 1'b0;
    tick();
  endtask
`endif

  initial begin
`ifdef OPSTAGE_FWD_EN
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; rs_addr = 10'd0;
`endif
    test_reset();
    test_imm();
    test_reg_none();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef OPSTAGE_FWD_EN
    test_forwarding();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand width in bits.
REQ-002 SHALL have parameter NUM_OPS, default 2, legal 1..4, the number of operand channels (ch0 = rs1, ch1 = rs2, ...).
REQ-003 SHALL have parameter STALL_W, default 16, the stall-counter width.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 opcode  in  7  opcode of the incoming instruction.
REQ-007 dec_data  in  NUM_OPS*XLEN  decoder/immediate value per channel; channel k occupies bits [k*XLEN +: XLEN].
REQ-008 rf_data  in  NUM_OPS*XLEN  regfile read value per channel, packed the same way.
REQ-009 in_valid / in_ready  in / out  1 each  upstream handshake.
REQ-010 out_valid / out_ready  out / in  1 each  downstream handshake.
REQ-011 flush  in  1  discard the held entry.
REQ-012 op_data  out  NUM_OPS*XLEN  registered operands.
REQ-013 op_class  out  2  registered class: 00 NONE, 01 IMM, 10 REG.
REQ-014 op_opcode  out  7  registered opcode.
REQ-015 stall_cnt  out  STALL_W  saturating count of back-pressure cycles.

Function
REQ-016 Class decode SHALL be combinational on opcode.
- IMM: opcode[6:3]==0000, or opcode[6:4]==001, or opcode[6:2]==11001.
- REG: opcode[6:4]==011, or opcode[6:2]==01011, or opcode[6:2]==10100.
- NONE: all other opcodes.
- IMM takes priority over REG.
REQ-017 in_ready SHALL equal (!out_valid || out_ready); it is combinational and has no dependency on in_valid.
REQ-018 Capture SHALL occur when (in_valid && in_ready && !flush). On capture, on the same edge:
- out_valid <= 1.
- op_opcode <= opcode.
- op_class <= decoded class.
REQ-019 On capture, each channel k SHALL load:
- IMM: dec_data[k].
- REG: rf_data[k] (or the forwarded value, see REQ-028).
- NONE: retain its previous value.
REQ-020 Without a capture, out_ready && out_valid SHALL clear out_valid; op_data, op_class and op_opcode SHALL hold.
REQ-021 A simultaneous capture and downstream accept SHALL replace the entry back-to-back, keeping out_valid=1 with one transfer per cycle.
REQ-022 While out_valid && !out_ready, the entry SHALL hold stable and in_ready SHALL be 0.
REQ-023 flush SHALL clear out_valid at the next edge and block capture in that cycle; op_data SHALL be unchanged.
REQ-024 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturate at all-ones, and never wrap.
REQ-025 Capture-to-output latency SHALL be exactly 1 cycle; there is no combinational path from opcode or data to any output.

Reset
REQ-026 While rst==0 at a posedge, all registers SHALL reset, with reset taking priority over flush and capture:
- out_valid=0, op_data=0, op_class=00, op_opcode=0, stall_cnt=0.
- Applied mid-transfer, the held entry SHALL be discarded.
REQ-027 During reset in_ready SHALL follow REQ-017 and so reads 1 once out_valid=0.

Configuration
REQ-028 Macro OPSTAGE_FWD_EN, when defined, SHALL add write-back forwarding with these ports:
- wb_en in 1, wb_addr in 5, wb_data in XLEN, rs_addr in NUM_OPS*5.
- On a REG capture, channel k SHALL load wb_data instead of rf_data[k] when wb_en && wb_addr==rs_addr[k] && wb_addr!=0.
- IMM and NONE captures SHALL ignore forwarding.
REQ-029 When OPSTAGE_FWD_EN is undefined, these ports SHALL be absent and REG captures SHALL always use rf_data.

Verification
REQ-030 The bench SHALL cover at least these directed scenarios (XLEN=32, NUM_OPS=2):
- IMM capture: opcode=0010011, dec_data={32'h5,32'hA}, rf_data={32'h1,32'h2} -> next cycle op_data={32'h5,32'hA}, op_class=01, out_valid=1.
- REG then NONE: opcode=0110011, rf_data={32'h11,32'h22}, then opcode=1100011 -> op_data stays {32'h11,32'h22}, op_class=00.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, op_data stable, stall_cnt=5; STALL_W=2 with 6 stall cycles -> stall_cnt=3.
- Flush with in_valid=1 -> out_valid=0 next cycle and op_data unchanged; rst=0 mid-stall -> all outputs 0 and stall_cnt=0.
- With OPSTAGE_FWD_EN: REG capture with rs_addr[0]=5, wb_en=1, wb_addr=5, wb_data=32'hDEAD -> ch0=32'hDEAD; repeat with wb_addr=0 -> ch0=rf_data[0].
